// File: rtl/pipelined_carry_adder.sv
// pipelined_carry_adder
//   Parametrised add/subtract unit. WIDTH-bit operands are split into
//   SEG_WIDTH-bit segments. Each pipeline stage adds one segment, and the
//   carry is registered between stages.
//   Operand segments that have not been added yet travel down a skew chain,
//   with b already inverted for subtract. Result segments that are already
//   done travel down a deskew chain, so the full sum leaves the last stage
//   aligned.
//   All stages advance together (global stall, no skid buffer).
//
// Ports
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready  operand beat handshake (in_ready = advance)
//   a, b                 WIDTH-bit operands
//   cin                  carry-in, add mode only
//   sub                  0: a+b+cin, 1: a-b (a + ~b + 1)
//   out_valid/out_ready  result beat handshake
//   sum                  result modulo 2^WIDTH
//   cout                 carry-out of MSB (sub mode: 1 = no borrow)
//   ovf                  signed two's-complement overflow
module pipelined_carry_adder #(
    parameter int WIDTH     = 32,
    parameter int SEG_WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NSTAGES = WIDTH / SEG_WIDTH;

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             c0;
    logic             a_msb_last;
    logic             b_msb_last;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign b_eff    = sub ? ~b : b;
    assign c0       = sub | cin;

    for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
        // OW : operand bits still to be added when entering this stage
        // RW : result bits known after this stage
        // REM: operand bits forwarded to the next stage
        localparam int OW  = WIDTH - k * SEG_WIDTH;
        localparam int RW  = (k + 1) * SEG_WIDTH;
        localparam int REM = OW - SEG_WIDTH;

        logic [OW-1:0]      op_a;
        logic [OW-1:0]      op_b;
        logic               op_c;
        logic               v_in;
        logic               a_msb_in;
        logic               b_msb_in;
        logic [RW-1:0]      res_in;
        logic [SEG_WIDTH:0] seg_sum;
        logic               load;

        logic               valid_d, valid_q;
        logic               carry_d, carry_q;
        logic               a_msb_d, a_msb_q;
        logic               b_msb_d, b_msb_q;
        logic [RW-1:0]      res_d, res_q;

        if (k == 0) begin : g_first
            assign op_a     = a;
            assign op_b     = b_eff;
            assign op_c     = c0;
            assign v_in     = in_valid;
            assign a_msb_in = a[WIDTH-1];
            assign b_msb_in = b_eff[WIDTH-1];
            assign res_in   = seg_sum[SEG_WIDTH-1:0];
        end else begin : g_next
            assign op_a     = g_stage[k-1].g_fwd.a_fwd_q;
            assign op_b     = g_stage[k-1].g_fwd.b_fwd_q;
            assign op_c     = g_stage[k-1].carry_q;
            assign v_in     = g_stage[k-1].valid_q;
            assign a_msb_in = g_stage[k-1].a_msb_q;
            assign b_msb_in = g_stage[k-1].b_msb_q;
            assign res_in   = {seg_sum[SEG_WIDTH-1:0], g_stage[k-1].res_q};
        end

        assign seg_sum = {1'b0, op_a[SEG_WIDTH-1:0]}
                       + {1'b0, op_b[SEG_WIDTH-1:0]}
                       + {{SEG_WIDTH{1'b0}}, op_c};

        // Data registers only load on real beats; a bubble moves just the
        // valid bit, so operands seen outside accepted beats never land.
        always_comb begin
            load    = adv && v_in;
            valid_d = adv ? v_in : valid_q;
            carry_d = load ? seg_sum[SEG_WIDTH] : carry_q;
            res_d   = load ? res_in : res_q;
            a_msb_d = load ? a_msb_in : a_msb_q;
            b_msb_d = load ? b_msb_in : b_msb_q;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                res_q   <= '0;
                a_msb_q <= 1'b0;
                b_msb_q <= 1'b0;
            end else begin
                valid_q <= valid_d;
                carry_q <= carry_d;
                res_q   <= res_d;
                a_msb_q <= a_msb_d;
                b_msb_q <= b_msb_d;
            end
        end

        if (REM > 0) begin : g_fwd
            logic [REM-1:0] a_fwd_d, a_fwd_q;
            logic [REM-1:0] b_fwd_d, b_fwd_q;

            always_comb begin
                a_fwd_d = load ? op_a[OW-1:SEG_WIDTH] : a_fwd_q;
                b_fwd_d = load ? op_b[OW-1:SEG_WIDTH] : b_fwd_q;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_fwd_q <= '0;
                    b_fwd_q <= '0;
                end else begin
                    a_fwd_q <= a_fwd_d;
                    b_fwd_q <= b_fwd_d;
                end
            end
        end
    end

    assign out_valid  = g_stage[NSTAGES-1].valid_q;
    assign sum        = g_stage[NSTAGES-1].res_q;
    assign cout       = g_stage[NSTAGES-1].carry_q;
    assign a_msb_last = g_stage[NSTAGES-1].a_msb_q;
    assign b_msb_last = g_stage[NSTAGES-1].b_msb_q;

    // Overflow is derived only from last-stage registers. After reset all
    // of these are 0, so ovf is 0 as well.
    assign ovf = (a_msb_last == b_msb_last) && (sum[WIDTH-1] != a_msb_last);

endmodule

// File: doc/pipelined_carry_adder.md
Name: pipelined_carry_adder

Overview:
- Parametrised, pipelined successor to the team's 4-bit ripple-carry adder.
- WIDTH-bit operands are split into SEG_WIDTH-bit segments. One segment is added per pipeline stage, and the carry is registered between stages. This gives timing closure at wide widths.
- Adds an add/subtract mode, a signed-overflow flag and a valid/ready handshake on both sides.
- Sits between operand-producing logic and result consumers in the datapath.

Parameters:
- WIDTH, 32, operand and result width in bits; must be a multiple of SEG_WIDTH.
- SEG_WIDTH, 8, bits added per stage; 1 <= SEG_WIDTH <= WIDTH.
- NSTAGES, WIDTH/SEG_WIDTH, derived (localparam); pipeline depth and latency in cycles.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block accepts a beat this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in; used in add mode only
- sub  input  1  0 = a+b+cin, 1 = a-b (a + ~b + 1, cin ignored)
- out_valid  output  1  result beat valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result, modulo 2^WIDTH
- cout  output  1  carry-out of MSB; in sub mode 1 = no borrow (a >= b unsigned)
- ovf  output  1  signed two's-complement overflow

Behaviour:
- Reset (rst_n low, asynchronous):
  - All stage valid bits, carry registers, skew/deskew registers and outputs clear to 0.
  - out_valid=0, sum=0, cout=0, ovf=0.
  - in_ready=1 from the first cycle after reset release.
  - Reset asserted mid-operation discards all in-flight beats; no partial result is ever presented.
- Advance:
  - adv = !out_valid || out_ready.
  - in_ready = adv (combinational).
  - All stages shift together when adv=1 and hold when adv=0. Global stall; no skid buffer.
- Accept:
  - A beat is accepted on a clock edge with in_valid && in_ready.
  - If in_valid=0 while adv=1, a bubble (valid=0) enters stage 0.
- Stage 0:
  - Registers segment 0 sum and carry: a[SEG-1:0] + b'[SEG-1:0] + c0.
  - b' = sub ? ~b : b.
  - c0 = sub ? 1 : cin.
  - Remaining operand segments are registered into a skew chain, with b already inverted.
- Stage k (1..NSTAGES-1):
  - Adds segment k using the registered carry from stage k-1.
  - Lower result segments travel through a deskew chain so the whole sum emerges aligned.
- Last stage:
  - Its registers drive sum, cout and out_valid directly; no combinational path from inputs to outputs.
  - ovf = (a_msb == b'_msb) && (sum_msb != a_msb). The operand MSBs are carried down the skew chain.
- Latency and throughput:
  - Exactly NSTAGES cycles from acceptance to out_valid with no stalls; each stall cycle adds one.
  - Throughput is one beat per cycle when out_ready=1.
- Handshake rules:
  - While out_valid=1 and out_ready=0, sum/cout/ovf/out_valid hold stable.
  - in_ready may depend combinationally on out_ready; in_valid must not depend on in_ready.
- Boundary cases:
  - NSTAGES=1 degenerates to a single registered full adder of WIDTH bits.
  - Wrap-around: sum is modulo 2^WIDTH with cout reporting the carry.
  - Ordering: beats emerge in acceptance order. Bubbles never produce out_valid.
  - Operand and control inputs are sampled only on accepted beats; changes at other times are ignored.

Test Plan:
- Reset then single add: WIDTH=32, SEG=8, a=0x0000_00FF, b=0x0000_0001, cin=0 → after exactly 4 cycles out_valid=1, sum=0x0000_0100, cout=0, ovf=0.
- Full carry ripple across all segments: a=0xFFFF_FFFF, b=0, cin=1 → sum=0, cout=1, ovf=0. Then a=0x7FFF_FFFF, b=1, cin=0 → sum=0x8000_0000, cout=0, ovf=1.
- Subtract mode: a=5, b=7, sub=1, cin=1 → sum=0xFFFF_FFFE, cout=0 (borrow), ovf=0, cin ignored. Then a=0x8000_0000, b=1, sub=1 → sum=0x7FFF_FFFF, cout=1, ovf=1.
- Back-to-back throughput: 100 random beats, in_valid=1, out_ready=1 → 100 results, one per cycle after 4-cycle fill, in order, matching a reference model.
- Backpressure: stream random beats while holding out_ready=0 for 3 cycles mid-stream → in_ready=0 during the stall, outputs stable, no beat lost or duplicated. Random in_valid gaps produce no spurious out_valid.
- Reset mid-flight: 3 beats in pipeline, pulse rst_n low asynchronously between edges → outputs go to 0 immediately, none of the 3 beats appear after release. Repeat at WIDTH=8, SEG_WIDTH=8 (NSTAGES=1) → latency 1 cycle.
